// File: rtl/local_injector.sv
// Local injection/ejection port between a core and its mesh router.
// TX side queues core packets for the router; RX side buffers one ejected packet.
`ifndef PL
`define PL 32
`endif
`ifndef CS
`define CS 4
`endif
`ifndef REN
`define REN 5
`endif

module local_injector #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [`CS-1:0]          router_X,
  input  logic [`CS-1:0]          router_Y,
  input  logic                    core_valid,
  output logic                    core_ready,
  input  logic [`CS-1:0]          core_dest_x,
  input  logic [`CS-1:0]          core_dest_y,
  input  logic [`PL-2-2*`CS:0]    core_payload,
  output logic [0:`PL-1]          router_data,
  input  logic                    router_avail,
  input  logic [0:`PL-1]          eject_data,
  output logic                    eject_avail,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [`PL-2-2*`CS:0]    rx_payload,
  output logic [7:0]              misroute_count,
  output logic [7:0]              overflow_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} tx_t;
  typedef enum logic {EMPTY, FULL} rx_t;

  logic [0:`PL-1] mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           alive;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [0:`PL-1] data_q;
  tx_t            tx_q;
  tx_t            tx_d;
  rx_t            rx_q;
  rx_t            rx_d;
  logic           cap;
  logic           drop;
  logic           misroute;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = core_valid && core_ready;
  assign pop   = !empty && router_avail;

  assign core_ready  = alive && !full;
  assign eject_avail = alive && (rx_q == EMPTY);
  assign rx_valid    = (rx_q == FULL);
  assign router_data = (tx_q == SEND) ? data_q : '0;

  // Handshakes stay low until the first edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alive <= 1'b0;
    else     alive <= 1'b1;
  end

  // Packet storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {1'b1, core_dest_x, core_dest_y, core_payload};
  end

  // FIFO pointers, wrapping modulo DEPTH with an extra lap bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // TX state register and the packet latched for the router.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= IDLE;
      data_q <= '0;
    end else begin
      tx_q <= tx_d;
      if (pop) data_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  // TX next state: every pop yields exactly one SEND cycle.
  always_comb begin
    tx_d = IDLE;
    if (pop) tx_d = SEND;
  end

  // RX next state and capture/drop decisions.
  always_comb begin
    rx_d = rx_q;
    cap  = 1'b0;
    drop = 1'b0;
    unique case (rx_q)
      EMPTY: begin
        if (alive && eject_data[0]) begin
          cap  = 1'b1;
          rx_d = FULL;
        end
      end
      FULL: begin
        if (eject_data[0] && rx_ready) cap = 1'b1;
        else if (eject_data[0])        drop = 1'b1;
        else if (rx_ready)             rx_d = EMPTY;
      end
      default: rx_d = EMPTY;
    endcase
  end

  assign misroute = cap && ((eject_data[1:`CS] != router_X) ||
                            (eject_data[`CS+1:2*`CS] != router_Y));

  // RX state, buffered payload and saturating statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q           <= EMPTY;
      rx_payload     <= '0;
      misroute_count <= '0;
      overflow_count <= '0;
    end else begin
      rx_q <= rx_d;
      if (cap) rx_payload <= eject_data[2*`CS+1:`PL-1];
      if (misroute && misroute_count != 8'hff)
        misroute_count <= misroute_count + 8'd1;
      if (drop && overflow_count != 8'hff)
        overflow_count <= overflow_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_local_injector.sv
// Scoreboard bench for local_injector: a queue-based model predicts each cycle,
// a negedge monitor compares DUT outputs against it.
`ifndef PL
`define PL 32
`endif
`ifndef CS
`define CS 4
`endif
`ifndef REN
`define REN 5
`endif

module tb_local_injector;
  localparam int DEPTH = 4;
  localparam int CS = `CS;
  localparam int PL = `PL;
  localparam int PW = PL - 1 - 2 * CS;

  typedef logic [0:PL-1] pkt_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CS-1:0] router_X = CS'(1);
  logic [CS-1:0] router_Y = CS'(1);
  logic          core_valid = 1'b0;
  logic          core_ready;
  logic [CS-1:0] core_dest_x = '0;
  logic [CS-1:0] core_dest_y = '0;
  logic [PW-1:0] core_payload = '0;
  pkt_t          router_data;
  logic          router_avail = 1'b0;
  pkt_t          eject_data = '0;
  logic          eject_avail;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [PW-1:0] rx_payload;
  logic [7:0]    misroute_count;
  logic [7:0]    overflow_count;

  local_injector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .router_X(router_X), .router_Y(router_Y),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_dest_x(core_dest_x), .core_dest_y(core_dest_y),
    .core_payload(core_payload),
    .router_data(router_data), .router_avail(router_avail),
    .eject_data(eject_data), .eject_avail(eject_avail),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_payload(rx_payload),
    .misroute_count(misroute_count), .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  pkt_t          m_fifo[$];
  pkt_t          m_exp_tx[$];
  bit            m_send;
  bit            m_alive;
  bit            m_full;
  logic [PW-1:0] m_pay;
  int            m_mis;
  int            m_ovf;
  bit            m_rdy;
  bit            m_pop;

  task automatic m_capture(input pkt_t p);
    m_full = 1'b1;
    m_pay  = p[2*CS+1:PL-1];
    if (p[1:CS] != router_X || p[CS+1:2*CS] != router_Y)
      m_mis = (m_mis < 255) ? m_mis + 1 : 255;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      m_exp_tx.delete();
      m_send  = 1'b0;
      m_alive = 1'b0;
      m_full  = 1'b0;
      m_pay   = '0;
      m_mis   = 0;
      m_ovf   = 0;
    end else begin
      m_rdy = m_alive && (m_fifo.size() < DEPTH);
      m_pop = (m_fifo.size() > 0) && router_avail;
      m_send = m_pop;
      if (m_pop) m_exp_tx.push_back(m_fifo.pop_front());
      if (core_valid && m_rdy)
        m_fifo.push_back({1'b1, core_dest_x, core_dest_y, core_payload});
      if (!m_full) begin
        if (m_alive && eject_data[0]) m_capture(eject_data);
      end else if (eject_data[0]) begin
        if (rx_ready) m_capture(eject_data);
        else m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
      end else if (rx_ready) begin
        m_full = 1'b0;
      end
      m_alive = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_router_data", 64'(router_data), 64'd0);
      chk("rst_core_ready", 64'(core_ready), 64'd0);
      chk("rst_eject_avail", 64'(eject_avail), 64'd0);
      chk("rst_rx_valid", 64'(rx_valid), 64'd0);
      chk("rst_rx_payload", 64'(rx_payload), 64'd0);
      chk("rst_misroute", 64'(misroute_count), 64'd0);
      chk("rst_overflow", 64'(overflow_count), 64'd0);
    end else begin
      chk("core_ready", 64'(core_ready),
          64'(m_alive && (m_fifo.size() < DEPTH)));
      chk("tx_valid", 64'(router_data[0]), 64'(m_send));
      if (router_data[0]) begin
        if (m_exp_tx.size() == 0) chk("tx_unexpected", 64'(router_data), 64'd0);
        else chk("tx_pkt", 64'(router_data), 64'(m_exp_tx.pop_front()));
      end else begin
        chk("tx_idle_zero", 64'(router_data), 64'd0);
      end
      chk("eject_avail", 64'(eject_avail), 64'(m_alive && !m_full));
      chk("rx_valid", 64'(rx_valid), 64'(m_full));
      if (m_full) chk("rx_payload", 64'(rx_payload), 64'(m_pay));
      chk("misroute_count", 64'(misroute_count), 64'(m_mis));
      chk("overflow_count", 64'(overflow_count), 64'(m_ovf));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic offer(input int dx, input int dy);
    core_valid   = 1'b1;
    core_dest_x  = CS'(dx);
    core_dest_y  = CS'(dy);
    core_payload = PW'($urandom);
  endtask

  function automatic pkt_t mk(input int dx, input int dy);
    logic [PW-1:0] pl;
    pl = PW'($urandom);
    return {1'b1, CS'(dx), CS'(dy), pl};
  endfunction

  pkt_t first_pkt;

  initial begin
    tick(3);
    rst = 1'b0;
    tick(2);

    // single packet to (2,1)
    router_avail = 1'b1;
    offer(2, 1);
    tick();
    core_valid = 1'b0;
    tick(3);

    // fill with the router stalled, then drain back-to-back
    router_avail = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      offer(i, 3 - i);
      tick();
    end
    core_valid = 1'b0;
    tick();
    router_avail = 1'b1;
    tick(DEPTH + 3);

    // packet for this node, held then released
    rx_ready = 1'b0;
    first_pkt = mk(1, 1);
    eject_data = first_pkt;
    tick();
    eject_data = '0;
    tick(2);
    // second packet while full: dropped, first retained
    eject_data = mk(1, 1);
    tick();
    eject_data = '0;
    tick();
    chk("retained_payload", 64'(rx_payload), 64'(first_pkt[2*CS+1:PL-1]));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick(2);

    // misrouted packet, then saturation of the misroute counter
    eject_data = mk(3, 3);
    tick();
    eject_data = '0;
    tick();
    rx_ready = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      eject_data = mk(3, 3);
      tick();
    end
    eject_data = '0;
    tick(2);
    chk("misroute_sat", 64'(misroute_count), 64'd255);

    // reset while the FIFO holds packets and one is on the wire
    rx_ready = 1'b0;
    router_avail = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(i + 4, i);
      tick();
    end
    core_valid = 1'b0;
    router_avail = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_router_data", 64'(router_data), 64'd0);
    chk("async_rst_core_ready", 64'(core_ready), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      core_valid   = 1'($urandom);
      core_dest_x  = CS'($urandom);
      core_dest_y  = CS'($urandom);
      core_payload = PW'($urandom);
      router_avail = ($urandom_range(0, 3) != 0);
      rx_ready     = 1'($urandom);
      if ($urandom_range(0, 9) < 3)
        eject_data = ($urandom_range(0, 1) == 0) ? mk(1, 1)
                     : mk($urandom_range(0, 15), $urandom_range(0, 15));
      else
        eject_data = '0;
      tick();
    end
    core_valid = 1'b0;
    eject_data = '0;
    tick(DEPTH + 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
